// File: rtl/run_controller.sv
// Core reset sequencer: hold, staggered per-channel release, then count RUN cycles until halt or restart.
// Registered outputs, one-edge response; define RUN_CTRL_WATCHDOG_EN to end RUN at MAX_CYCLES via TIMEOUT.
module run_controller #(
    parameter int              NUM_RST     = 4,
    parameter int              HOLD_CYCLES = 2,
    parameter int              STAGGER     = 1,
    parameter int              CNT_W       = 32,
    parameter longint unsigned MAX_CYCLES  = 40,
    parameter int              HALT_STABLE = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               restart,
    input  logic               halt_req,
    output logic [NUM_RST-1:0] core_rst_n,
    output logic               running,
    output logic               done,
    output logic               timeout,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        S_HOLD    = 3'd0,
        S_RELEASE = 3'd1,
        S_RUN     = 3'd2,
        S_DONE    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    if (NUM_RST < 1 || NUM_RST > 16) begin : g_bad_num_rst
        $error("NUM_RST out of range 1..16");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
        $error("HOLD_CYCLES out of range 1..255");
    end
    if (STAGGER < 1 || STAGGER > 15 || HALT_STABLE < 1 || HALT_STABLE > 15) begin : g_bad_small
        $error("STAGGER or HALT_STABLE out of range 1..15");
    end
    if (MAX_CYCLES < 1) begin : g_bad_max
        $error("MAX_CYCLES must be at least 1");
    end

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] REL_LAST  = 8'((NUM_RST - 1) * STAGGER);
    localparam logic [3:0] HS_LAST   = 4'(HALT_STABLE - 1);
`ifdef RUN_CTRL_WATCHDOG_EN
    localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_VAL  = CNT_W'(MAX_CYCLES);
`endif

    state_t             state_q;
    logic [7:0]         hc_q;
    logic [7:0]         sc_q;
    logic [3:0]         hs_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NUM_RST-1:0] core_q;
    logic               running_q;
    logic               done_q;
`ifdef RUN_CTRL_WATCHDOG_EN
    logic               timeout_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_HOLD;
            hc_q      <= '0;
            sc_q      <= '0;
            hs_q      <= '0;
            cnt_q     <= '0;
            core_q    <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef RUN_CTRL_WATCHDOG_EN
            timeout_q <= 1'b0;
`endif
        end else if (restart) begin
            state_q   <= S_HOLD;
            hc_q      <= '0;
            sc_q      <= '0;
            hs_q      <= '0;
            cnt_q     <= '0;
            core_q    <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef RUN_CTRL_WATCHDOG_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_HOLD: begin
                    core_q <= '0;
                    if (hc_q == HOLD_LAST) begin
                        hc_q    <= '0;
                        sc_q    <= '0;
                        state_q <= S_RELEASE;
                    end else begin
                        hc_q <= hc_q + 8'd1;
                    end
                end
                S_RELEASE: begin
                    // Channel i comes out of reset on the edge where sc reaches i*STAGGER.
                    for (int i = 0; i < NUM_RST; i++) begin
                        if (sc_q == 8'(i * STAGGER)) core_q[i] <= 1'b1;
                    end
                    if (sc_q == REL_LAST) begin
                        state_q   <= S_RUN;
                        running_q <= 1'b1;
                        cnt_q     <= '0;
                        hs_q      <= '0;
                    end else begin
                        sc_q <= sc_q + 8'd1;
                    end
                end
                S_RUN: begin
                    if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    hs_q <= halt_req ? hs_q + 4'd1 : 4'd0;
                    if (halt_req && hs_q == HS_LAST) begin
                        state_q   <= S_DONE;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end
`ifdef RUN_CTRL_WATCHDOG_EN
                    else if (cnt_q == MAX_LAST) begin
                        cnt_q     <= MAX_VAL;
                        state_q   <= S_TIMEOUT;
                        running_q <= 1'b0;
                        timeout_q <= 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    core_q <= '1;
                end
`ifdef RUN_CTRL_WATCHDOG_EN
                S_TIMEOUT: begin
                    core_q <= '1;
                end
`endif
                default: begin
                    state_q   <= S_HOLD;
                    hc_q      <= '0;
                    sc_q      <= '0;
                    hs_q      <= '0;
                    cnt_q     <= '0;
                    core_q    <= '0;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
`ifdef RUN_CTRL_WATCHDOG_EN
                    timeout_q <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign core_rst_n  = core_q;
    assign running     = running_q;
    assign done        = done_q;
    assign cycle_count = cnt_q;
    assign state       = state_q;
`ifdef RUN_CTRL_WATCHDOG_EN
    assign timeout     = timeout_q;
`else
    assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_run_controller.sv
// Randomized + directed bench for run_controller; expected outputs come from a timeline model
// (edges since sequence start, halt run length) queued per edge and checked by a separate monitor.
module tb_run_controller;

    localparam int              NUM_RST     = 4;
    localparam int              HOLD_CYCLES = 2;
    localparam int              STAGGER     = 1;
    localparam int              CNT_W       = 32;
    localparam longint unsigned MAX_CYCLES  = 40;
    localparam int              HALT_STABLE = 3;
    localparam int              T_RUN       = HOLD_CYCLES + 1 + (NUM_RST - 1) * STAGGER;
    localparam longint unsigned CNT_MAX     = (64'd1 << CNT_W) - 64'd1;
`ifdef RUN_CTRL_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    typedef struct packed {
        logic [2:0]         st;
        logic [NUM_RST-1:0] core;
        logic [2:0]         flags;
        logic [CNT_W-1:0]   cnt;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               restart;
    logic               halt_req;
    logic [NUM_RST-1:0] core_rst_n;
    logic               running;
    logic               done;
    logic               timeout;
    logic [CNT_W-1:0]   cycle_count;
    logic [2:0]         state;

    run_controller #(
        .NUM_RST(NUM_RST), .HOLD_CYCLES(HOLD_CYCLES), .STAGGER(STAGGER),
        .CNT_W(CNT_W), .MAX_CYCLES(MAX_CYCLES), .HALT_STABLE(HALT_STABLE)
    ) dut (
        .clk(clk), .reset(reset), .restart(restart), .halt_req(halt_req),
        .core_rst_n(core_rst_n), .running(running), .done(done), .timeout(timeout),
        .cycle_count(cycle_count), .state(state)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    exp_t exp_q[$];

    // Model: edges since reset/restart, finish kind (0 none, 1 done, 2 timeout), halt run length, run count.
    int              m_t    = 0;
    int              m_fin  = 0;
    int              m_ones = 0;
    longint unsigned m_cnt  = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_step(input logic r, input logic rs, input logic h);
        exp_t e;
        longint unsigned prev;
        if (!r || rs) begin
            m_t = 0; m_fin = 0; m_ones = 0; m_cnt = 0;
        end else if (m_fin == 0) begin
            if (m_t >= T_RUN) begin
                prev = m_cnt;
                if (m_cnt < CNT_MAX) m_cnt++;
                m_ones = h ? m_ones + 1 : 0;
                if (m_ones == HALT_STABLE) m_fin = 1;
                else if (WD && prev == MAX_CYCLES - 1) m_fin = 2;
            end
            m_t++;
        end
        if (m_fin == 1)            e.st = 3'd3;
        else if (m_fin == 2)       e.st = 3'd4;
        else if (m_t < HOLD_CYCLES) e.st = 3'd0;
        else if (m_t < T_RUN)      e.st = 3'd1;
        else                       e.st = 3'd2;
        for (int i = 0; i < NUM_RST; i++)
            e.core[i] = (m_fin != 0) || (m_t >= HOLD_CYCLES + 1 + i * STAGGER);
        e.flags = {e.st == 3'd2, m_fin == 1, m_fin == 2};
        e.cnt   = CNT_W'(m_cnt);
        exp_q.push_back(e);
    endfunction

    task automatic cyc(input logic r, input logic rs, input logic h);
        @(negedge clk);
        reset = r; restart = rs; halt_req = h;
        model_step(r, rs, h);
        @(posedge clk);
        #2;
    endtask

    task automatic run_to_cnt(input longint unsigned target);
        int g = 0;
        while (m_cnt != target && g < 300) begin
            cyc(1'b1, 1'b0, 1'b0);
            g++;
        end
        chk("reach_cnt", cycle_count, target);
    endtask

    task automatic chk_cleared(input string nm);
        chk({nm, "_state"}, state, 0);
        chk({nm, "_core"}, core_rst_n, 0);
        chk({nm, "_flags"}, {running, done, timeout}, 0);
        chk({nm, "_cnt"}, cycle_count, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_state", state, e.st);
                chk("sb_core", core_rst_n, e.core);
                chk("sb_flags", {running, done, timeout}, e.flags);
                chk("sb_cnt", cycle_count, e.cnt);
            end
        end
    end

    logic [NUM_RST-1:0] rel_seq [6];
    logic               hpat    [6];

    initial begin : stim
        logic r, rs, h;
        int   hp;
        rel_seq = '{4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'hF};
        hpat    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        reset = 1'b1; restart = 1'b0; halt_req = 1'b0;
        #2 reset = 1'b0;
        #1 chk_cleared("reset");

        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1, 1'b0, 1'b0);
            chk("release_seq", core_rst_n, rel_seq[k]);
        end
        chk("run_entry_running", running, 1);

        // Halt held from RUN cycle 10.
        run_to_cnt(10);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b0, 1'b1);
            chk("halt10_done", done, k == 2);
        end
        chk("halt10_cnt", cycle_count, 13);
        chk("halt10_running", running, 0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        chk("done_sticky", done, 1);
        chk("done_cnt_frozen", cycle_count, 13);
        chk("done_core", core_rst_n, 4'hF);

        cyc(1'b1, 1'b1, 1'b0);
        chk_cleared("restart");

        // Broken halt run: 1,1,0,1,1,1.
        for (int k = 0; k < T_RUN; k++) cyc(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1, 1'b0, hpat[k]);
            chk("halt_pattern_done", done, k == 5);
        end

        // No halt: watchdog expiry (or free running without it).
        cyc(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < T_RUN + (WD ? 40 : 100); k++) cyc(1'b1, 1'b0, 1'b0);
        chk("wd_timeout", timeout, WD);
        chk("wd_cnt", cycle_count, WD ? 40 : 100);
        chk("wd_done", done, 0);
        chk("wd_running", running, !WD);
        chk("wd_core", core_rst_n, 4'hF);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        chk("wd_sticky", timeout, WD);
        chk("wd_cnt_after", cycle_count, WD ? 40 : 102);

        // Third halt high on the 39->40 edge: halt wins over watchdog.
        cyc(1'b1, 1'b1, 1'b0);
        run_to_cnt(37);
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b1);
        chk("coin_done", done, 1);
        chk("coin_timeout", timeout, 0);
        chk("coin_cnt", cycle_count, 40);

        // Asynchronous reset in the middle of RUN.
        cyc(1'b1, 1'b1, 1'b0);
        run_to_cnt(5);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 chk_cleared("arst_mid_run");
        cyc(1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 400; k++) begin
            hp = (k < 200) ? 1 : 6;
            r  = ($urandom_range(0, 149) != 0);
            rs = ($urandom_range(0, 59) == 0);
            h  = ($urandom_range(0, 7) < hp);
            cyc(r, rs, h);
        end
        cyc(1'b1, 1'b0, 1'b0);
        chk("sb_drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 The block SHALL expose parameter NUM_RST, default 4: number of independent core reset channels, range 1..16.
REQ-002 The block SHALL expose parameter HOLD_CYCLES, default 2: cycles all channels stay in reset after release of `reset`, range 1..255.
REQ-003 The block SHALL expose parameter STAGGER, default 1: cycles between consecutive channel releases, range 1..15.
REQ-004 The block SHALL expose parameter CNT_W, default 32: width of the run-cycle counter.
REQ-005 The block SHALL expose parameter MAX_CYCLES, default 40: watchdog limit in RUN cycles, range 1..2^CNT_W-1.
REQ-006 The block SHALL expose parameter HALT_STABLE, default 3: consecutive halt_req cycles required to finish, range 1..15.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-008 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-009 The block SHALL have port restart, input, 1 bit: synchronous request to rerun the sequence.
REQ-010 The block SHALL have port halt_req, input, 1 bit: halt indication from the core.
REQ-011 The block SHALL have port core_rst_n, output, NUM_RST bits: per-channel active-low core resets.
REQ-012 The block SHALL have ports running, done and timeout, outputs, 1 bit each: status flags.
REQ-013 The block SHALL have port cycle_count, output, CNT_W bits: RUN cycles elapsed.
REQ-014 The block SHALL have port state, output, 3 bits: current FSM state.

Function
REQ-015 The FSM SHALL have states HOLD=0, RELEASE=1, RUN=2, DONE=3 and TIMEOUT=4; all other encodings SHALL go to HOLD on the next edge.
REQ-016 In HOLD, core_rst_n SHALL be all 0; after HOLD_CYCLES edges in HOLD the FSM SHALL enter RELEASE.
REQ-017 In RELEASE, stagger counter sc SHALL start at 0; on the edge where sc == i*STAGGER, core_rst_n[i] SHALL go to 1 and stay 1.
REQ-018 The FSM SHALL enter RUN on the same edge that releases channel NUM_RST-1; running SHALL be 1 only in RUN.
REQ-019 cycle_count SHALL be 0 on RUN entry, increment by 1 per RUN cycle, saturate at all-ones, and hold its value in DONE and TIMEOUT.
REQ-020 The halt stability counter SHALL increment each RUN cycle with halt_req=1, clear on halt_req=0, and cause entry to DONE on the edge where it reaches HALT_STABLE.
REQ-021 In DONE and TIMEOUT, done or timeout respectively SHALL be 1 and sticky, and core_rst_n SHALL remain all 1.
REQ-022 restart=1 in any state SHALL enter HOLD on the next edge, clearing cycle_count, the counters and the flags, and driving core_rst_n all 0.
REQ-023 Priority SHALL be restart > halt completion > watchdog timeout when they coincide on the same edge.

Reset
REQ-024 reset=0 SHALL force, asynchronously: state=HOLD, core_rst_n=0, running=0, done=0, timeout=0, cycle_count=0, all internal counters 0.
REQ-025 On release of reset, the HOLD count SHALL begin at the first rising clk edge.
REQ-026 Assertion of reset mid-RUN SHALL abort to the same values with no additional clock edge required.

Configuration
REQ-027 With RUN_CTRL_WATCHDOG_EN defined, the edge where RUN has cycle_count == MAX_CYCLES-1 SHALL set cycle_count=MAX_CYCLES and enter TIMEOUT.
REQ-028 Without RUN_CTRL_WATCHDOG_EN, timeout SHALL be tied to 0, the TIMEOUT state SHALL be unreachable, and RUN SHALL end only by halt, restart or reset.

Verification (defaults; watchdog enabled unless stated)
REQ-029 reset low 2 cycles then high -> core_rst_n=0000 for 2 edges, then 0001, 0011, 0111, 1111 on successive edges; running=1 with 1111.
REQ-030 halt_req held high from RUN cycle 10 -> done=1 on the 3rd high edge; cycle_count frozen at 13; running=0.
REQ-031 halt_req pattern 1,1,0,1,1,1 -> done asserts only after the final three highs.
REQ-032 halt_req=0 throughout -> timeout=1 with cycle_count=40; done=0; core_rst_n=1111.
REQ-033 3rd halt_req high coincides with cycle_count 39->40 -> done=1, timeout=0.
REQ-034 restart pulse in DONE -> state=HOLD, flags=0, core_rst_n=0000, then the full sequence repeats; reset=0 mid-RUN -> all REQ-024 values immediately. The watchdog build with the macro undefined runs 100 cycles with timeout=0.
